vga2_tile_framebuffer: RTL and testbench



---
 rtl/vga2_tile_framebuffer.sv | 181 ++++++++++++++++++
 tb/tb_vga2_tile_framebuffer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga2_tile_framebuffer.sv
// Tile-mapped pixel source for the VGA2 interface: a 3-bit colour per tile,
// a valid/ready tile write port and a sweep engine that zeroes the map.
module vga2_tile_framebuffer #(
    parameter int HAddrSize        = 11,
    parameter int HVisibleArea     = 800,
    parameter int HFrontPorch      = 56,
    parameter int HSyncPulse       = 120,
    parameter int HBackPorch       = 64,
    parameter int VAddrSize        = 11,
    parameter int VVisibleArea     = 600,
    parameter int VFrontPorch      = 37,
    parameter int VSyncPulse       = 6,
    parameter int VBackPorch       = 23,
    parameter int TileShift        = 3,
    parameter int ColAddrSize      = 7,
    parameter int RowAddrSize      = 7,
    parameter int WriteInBlankOnly = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [ColAddrSize-1:0] wr_col,
    input  logic [RowAddrSize-1:0] wr_row,
    input  logic [2:0]             wr_color,
    output logic                   wr_error,
    input  logic                   clear_req,
    output logic                   clear_busy,
    output logic                   frame_start,
    output logic                   color_r,
    output logic                   color_g,
    output logic                   color_b
);

    localparam int HTotal = HVisibleArea + HFrontPorch + HSyncPulse + HBackPorch;
    localparam int VTotal = VVisibleArea + VFrontPorch + VSyncPulse + VBackPorch;
    localparam int Cols   = HVisibleArea >> TileShift;
    localparam int Rows   = VVisibleArea >> TileShift;
    localparam int Depth  = Cols * Rows;
    localparam int AddrW  = (Depth > 1) ? $clog2(Depth) : 1;

    localparam logic [HAddrSize-1:0] HLast = HAddrSize'(HTotal - 1);
    localparam logic [VAddrSize-1:0] VLast = VAddrSize'(VTotal - 1);
    localparam logic [HAddrSize-1:0] HVis  = HAddrSize'(HVisibleArea);
    localparam logic [VAddrSize-1:0] VVis  = VAddrSize'(VVisibleArea);
    localparam logic [AddrW-1:0]     ClrLast = AddrW'(Depth - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    // Handshake: a write is taken at a rising edge where wr_valid & wr_ready;
    // wr_ready never depends on wr_valid, and a taken out-of-range write only
    // raises the sticky wr_error.

    logic [HAddrSize-1:0] h_q, h_d, fh_q, fh_d;
    logic [VAddrSize-1:0] v_q, v_d, fv_q, fv_d;
    logic [0:0]           state_q, state_d;
    logic [AddrW-1:0]     clr_addr_q, clr_addr_d;
    logic [2:0]           color_q, color_d;
    logic                 err_q, err_d;
    logic                 fs_q, fs_d;

    logic [2:0]           mem_q [Depth];
    logic                 mem_we;
    logic [AddrW-1:0]     mem_waddr;
    logic [2:0]           mem_wdata;
    logic [AddrW-1:0]     rd_addr;
    logic [AddrW-1:0]     wr_addr;
    logic                 disp_vis, fetch_vis, in_range, wr_fire;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (h_q == HLast) begin
            h_d = '0;
            v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
        end else begin
            h_d = h_q + 1'b1;
        end
    end

    // The fetch counter runs one pixel ahead so the registered read lines up
    // with the display position.
    always_comb begin
        fh_d = fh_q;
        fv_d = fv_q;
        if (fh_q == HLast) begin
            fh_d = '0;
            fv_d = (fv_q == VLast) ? '0 : fv_q + 1'b1;
        end else begin
            fh_d = fh_q + 1'b1;
        end
    end

    assign disp_vis  = (h_q < HVis) && (v_q < VVis);
    assign fetch_vis = (fh_q < HVis) && (fv_q < VVis);
    assign rd_addr   = AddrW'(int'(fv_q >> TileShift) * Cols + int'(fh_q >> TileShift));
    assign wr_addr   = AddrW'(int'(wr_row) * Cols + int'(wr_col));
    assign in_range  = (int'(wr_col) < Cols) && (int'(wr_row) < Rows);

    assign wr_ready  = (state_q == ST_IDLE) && !clear_req &&
                       ((WriteInBlankOnly == 0) || !disp_vis);
    assign wr_fire   = wr_valid && wr_ready && reset;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == ST_CLEAR) begin
            if (clr_addr_q == ClrLast) begin
                state_d = ST_IDLE;
            end else begin
                clr_addr_d = clr_addr_q + 1'b1;
            end
        end else if (clear_req) begin
            state_d    = ST_CLEAR;
            clr_addr_d = '0;
        end
    end

    // The sweep owns the write port while it runs; the tile port is only
    // ready in IDLE, so the two never collide.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_color;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_q;
            mem_wdata = 3'b000;
        end else if (wr_fire && in_range) begin
            mem_we = 1'b1;
        end
    end

    always_comb begin
        color_d = 3'b000;
        if (fetch_vis) begin
            color_d = mem_q[rd_addr];
        end
        err_d = err_q || (wr_fire && !in_range);
        fs_d  = (fh_q == '0) && (fv_q == '0);
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            h_q        <= '0;
            v_q        <= '0;
            fh_q       <= HAddrSize'(1);
            fv_q       <= '0;
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            color_q    <= 3'b000;
            err_q      <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            fh_q       <= fh_d;
            fv_q       <= fv_d;
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            color_q    <= color_d;
            err_q      <= err_d;
            fs_q       <= fs_d;
        end
    end

    assign clear_busy  = (state_q == ST_CLEAR);
    assign wr_error    = err_q;
    assign frame_start = fs_q;
    assign color_r     = color_q[2];
    assign color_g     = color_q[1];
    assign color_b     = color_q[0];

endmodule

// File: tb/tb_vga2_tile_framebuffer.sv
// Bench for vga2_tile_framebuffer on a shrunken raster (80x54 total, 8x6 tiles),
// with one instance writing any time and one writing in blanking only.
module tb_vga2_tile_framebuffer;

    localparam int HV = 64, HFP = 4, HS = 8, HBP = 4, HT = HV + HFP + HS + HBP;
    localparam int VV = 48, VFP = 2, VS = 2, VBP = 2, VT = VV + VFP + VS + VBP;
    localparam int TS = 3, TILE = 1 << TS;
    localparam int COLS = HV / TILE, ROWS = VV / TILE, DEPTH = COLS * ROWS;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0, wr_valid = 1'b0, clear_req = 1'b0;
    logic [6:0] wr_col = '0, wr_row = '0;
    logic [2:0] wr_color = '0;

    logic rdy0, err0, busy0, fs0, r0, g0, b0;
    logic rdy1, err1, busy1, fs1, r1, g1, b1;

    vga2_tile_framebuffer #(
        .HVisibleArea(HV), .HFrontPorch(HFP), .HSyncPulse(HS), .HBackPorch(HBP),
        .VVisibleArea(VV), .VFrontPorch(VFP), .VSyncPulse(VS), .VBackPorch(VBP),
        .TileShift(TS), .WriteInBlankOnly(0)
    ) u_dut0 (
        .clock(clk), .reset(rst_n), .wr_valid(wr_valid), .wr_ready(rdy0),
        .wr_col(wr_col), .wr_row(wr_row), .wr_color(wr_color), .wr_error(err0),
        .clear_req(clear_req), .clear_busy(busy0), .frame_start(fs0),
        .color_r(r0), .color_g(g0), .color_b(b0)
    );

    vga2_tile_framebuffer #(
        .HVisibleArea(HV), .HFrontPorch(HFP), .HSyncPulse(HS), .HBackPorch(HBP),
        .VVisibleArea(VV), .VFrontPorch(VFP), .VSyncPulse(VS), .VBackPorch(VBP),
        .TileShift(TS), .WriteInBlankOnly(1)
    ) u_dut1 (
        .clock(clk), .reset(rst_n), .wr_valid(wr_valid), .wr_ready(rdy1),
        .wr_col(wr_col), .wr_row(wr_row), .wr_color(wr_color), .wr_error(err1),
        .clear_req(clear_req), .clear_busy(busy1), .frame_start(fs1),
        .color_r(r1), .color_g(g1), .color_b(b1)
    );

    // Model: time since reset gives the raster position; the map is an array
    // with a known flag per tile.
    int         n_cmp = 0, n_fail = 0;
    int         t = 0;
    bit         m_valid = 0, m_busy = 0, m_fs = 0;
    int         m_clr = 0;
    logic [2:0] m_mem [2][DEPTH];
    bit         m_known [2][DEPTH];
    bit         m_err [2];
    logic [2:0] m_color [2];
    bit         m_ckn [2];
    logic [1:0] last_rdy = '0;

    function automatic int hpos(int tt); return tt % HT; endfunction
    function automatic int vpos(int tt); return (tt / HT) % VT; endfunction
    function automatic bit vis(int tt); return hpos(tt) < HV && vpos(tt) < VV; endfunction
    function automatic int tile_of(int tt);
        return (vpos(tt) / TILE) * COLS + hpos(tt) / TILE;
    endfunction
    function automatic bit model_ready(int k, bit creq);
        return !m_busy && !creq && (k == 0 || !vis(t));
    endfunction
    function automatic logic [2:0] pix(int k);
        return (k == 0) ? {r0, g0, b0} : {r1, g1, b1};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0d h=%0d v=%0d)",
                     name, act, exp, t, hpos(t), vpos(t));
        end
    endtask

    task automatic compare();
        if (!m_valid) return;
        chk("busy0", busy0, m_busy);
        chk("busy1", busy1, m_busy);
        chk("ready0", rdy0, model_ready(0, clear_req));
        chk("ready1", rdy1, model_ready(1, clear_req));
        chk("err0", err0, m_err[0]);
        chk("err1", err1, m_err[1]);
        chk("fs0", fs0, m_fs);
        chk("fs1", fs1, m_fs);
        for (int k = 0; k < 2; k++) begin
            if (m_ckn[k]) chk(k == 0 ? "color0" : "color1", pix(k), m_color[k]);
        end
    endtask

    task automatic model_step();
        int  a;
        bit  acc [2];
        if (!rst_n) begin
            t = 0; m_fs = 0; m_busy = 1; m_clr = 0; m_valid = 1;
            for (int k = 0; k < 2; k++) begin
                m_err[k] = 0; m_color[k] = 3'b000; m_ckn[k] = 1;
                for (int i = 0; i < DEPTH; i++) m_known[k][i] = 0;
            end
            return;
        end
        if (!m_valid) return;
        for (int k = 0; k < 2; k++) acc[k] = wr_valid && model_ready(k, clear_req);
        for (int k = 0; k < 2; k++) begin
            if (vis(t + 1)) begin
                m_color[k] = m_mem[k][tile_of(t + 1)];
                m_ckn[k]   = m_known[k][tile_of(t + 1)];
            end else begin
                m_color[k] = 3'b000;
                m_ckn[k]   = 1;
            end
            if (m_busy) begin
                m_mem[k][m_clr] = 3'b000; m_known[k][m_clr] = 1;
            end else if (acc[k]) begin
                if (int'(wr_col) < COLS && int'(wr_row) < ROWS) begin
                    a = int'(wr_row) * COLS + int'(wr_col);
                    m_mem[k][a] = wr_color; m_known[k][a] = 1;
                end else begin
                    m_err[k] = 1;
                end
            end
        end
        if (m_busy) begin
            m_clr++;
            if (m_clr == DEPTH) m_busy = 0;
        end else if (clear_req) begin
            m_busy = 1; m_clr = 0;
        end
        t++;
        m_fs = (hpos(t) == 0 && vpos(t) == 0);
    endtask

    task automatic tick();
        #1;
        last_rdy = {rdy1, rdy0};
        compare();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 0; wr_valid = 0; clear_req = 0;
        repeat (n) tick();
        rst_n = 1;
    endtask

    task automatic sweep_len(input int creq_at, output int cnt);
        cnt = 0;
        while (busy0 == 1'b1 && cnt < 500) begin
            clear_req = (cnt == creq_at);
            cnt++;
            tick();
        end
        clear_req = 0;
    endtask

    task automatic do_write(input int c, input int r, input int colr);
        bit done0 = 0, done1 = 0;
        int n = 0;
        wr_valid = 1; wr_col = 7'(c); wr_row = 7'(r); wr_color = 3'(colr);
        while (!(done0 && done1) && n < 2 * FRAME) begin
            if (model_ready(0, clear_req)) done0 = 1;
            if (model_ready(1, clear_req)) done1 = 1;
            tick();
            n++;
        end
        wr_valid = 0;
        if (!(done0 && done1)) chk("write_timeout", n, -1);
    endtask

    task automatic wait_pos(input int h, input int v);
        int n = 0;
        while (!(hpos(t) == h && vpos(t) == v) && n < 2 * FRAME) begin
            tick();
            n++;
        end
        if (n >= 2 * FRAME) chk("wait_pos_timeout", n, -1);
    endtask

    initial begin
        int cnt, nz, win, fsc;
        do_reset(2);
        // First sweep after reset and a black first frame.
        sweep_len(-1, cnt);
        chk("first_sweep_len", cnt, DEPTH);
        nz = 0;
        while (t < FRAME - 1) begin
            if (pix(0) != 3'b000 || pix(1) != 3'b000) nz++;
            tick();
        end
        chk("first_frame_black", nz, 0);

        // Single tile, then one whole frame scanned.
        do_write(2, 1, 6);
        wait_pos(0, 0);
        win = 0; nz = 0; fsc = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (fs0) fsc++;
            if (hpos(t) >= 16 && hpos(t) <= 23 && vpos(t) >= 8 && vpos(t) <= 15) begin
                if (pix(0) == 3'b110) win++;
            end else if (pix(0) != 3'b000) begin
                nz++;
            end
            tick();
        end
        chk("tile_pixels", win, 64);
        chk("outside_black", nz, 0);
        chk("fs_per_frame", fsc, 1);
        chk("fs_period", fs0, 1);

        // Out-of-range writes at the first illegal column and row.
        do_write(COLS, 0, 5);
        do_write(0, ROWS, 5);
        chk("err_set0", err0, 1);
        chk("err_set1", err1, 1);
        repeat (200) tick();
        chk("err_sticky", err0, 1);

        // Blank-only instance waits for the end of the visible line.
        wait_pos(0, 0);
        wr_valid = 1; wr_col = 7'd3; wr_row = 7'd3; wr_color = 3'd5;
        cnt = 0;
        tick();
        while (!last_rdy[1] && cnt < 500) begin
            cnt++;
            tick();
        end
        wr_valid = 0;
        chk("blank_wait", cnt, HV);

        // Clear request beats a simultaneous write; a repeat request is ignored.
        wr_valid = 1; wr_col = 7'd1; wr_row = 7'd1; wr_color = 3'd7; clear_req = 1;
        tick();
        wr_valid = 0; clear_req = 0;
        chk("clear_wins", busy0, 1);
        sweep_len(30, cnt);
        chk("sweep_no_extend", cnt, DEPTH);

        // Reset in the middle of a sweep, then in the middle of a frame.
        clear_req = 1; tick(); clear_req = 0;
        repeat (20) tick();
        do_reset(1);
        chk("rst_sweep_color", pix(0), 0);
        chk("rst_sweep_fs", fs0, 0);
        chk("rst_sweep_busy", busy0, 1);
        sweep_len(-1, cnt);
        chk("rst_sweep_len", cnt, DEPTH);
        wait_pos(40, 24);
        do_reset(1);
        chk("rst_frame_color", pix(0), 0);
        chk("rst_frame_err", err0, 0);
        sweep_len(-1, cnt);
        chk("rst_frame_len", cnt, DEPTH);

        // Random traffic against the model.
        for (int i = 0; i < 2 * FRAME; i++) begin
            wr_valid  = ($urandom_range(0, 3) == 0);
            wr_col    = 7'($urandom_range(0, COLS + 1));
            wr_row    = 7'($urandom_range(0, ROWS + 1));
            wr_color  = 3'($urandom_range(0, 7));
            clear_req = ($urandom_range(0, 999) == 0);
            tick();
        end
        wr_valid = 0; clear_req = 0;
        repeat (FRAME) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
